ctrl_fsm_multicycle: RTL and testbench
======================================

CTRL_FSM_MULTICYCLE -- requirements
Module: ctrl_fsm_multicycle

Interface
REQ-001 SHALL have parameter OP_W, default 6, opcode width.
REQ-002 SHALL have parameter ALUOP_W, default 3, ALU_op_o width.
REQ-003 SHALL have parameter CNT_W, default 16, retire counter width.
REQ-004 SHALL have parameter MEM_WAIT_MAX, default 15, max memory wait cycles; 0 disables timeout.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Ports (name, direction, width, meaning):
 clk_i  in  1  clock, rising edge.
 rst_i  in  1  async active-low reset.
 instr_op_i  in  OP_W  opcode field from IR.
 mem_ready_i  in  1  memory access done this cycle.
 pc_write_o  out  1  PC <= PC+4.
 ir_write_o  out  1  load IR.
 mem_read_o / mem_write_o  out  1 each  memory strobes.
 RegWrite_o, RegDst_o, ALUSrc_o, memtoreg_o, Branch_o, jump_o  out  1 each  datapath controls.
 ALU_op_o  out  ALUOP_W  ALU control class.
 state_o  out  3  current FSM state.
 illegal_o  out  1  one-cycle pulse, unknown opcode.
 err_o  out  1  memory timeout, sticky.
 retire_cnt_o  out  CNT_W  retired instruction count.

Function
REQ-007 SHALL be a Moore FSM: IDLE, IFETCH, DECODE, EXEC, MEM, WB, ERROR; all outputs decoded from state and latched opcode op_q.
REQ-008 IDLE: all outputs 0; next edge -> IFETCH.
REQ-009 IFETCH: mem_read_o=1; on mem_ready_i=1, ir_write_o=1 and pc_write_o=1 that cycle, -> DECODE; else stay.
REQ-010 DECODE: op_q <= instr_op_i; legal -> EXEC; illegal -> illegal_o=1 this cycle, -> IFETCH, not retired.
REQ-011 Opcodes: R 000000, addi 001000, slti 001010, lw 100011, sw 101011, beq 000100, j 000010 (see REQ-021).
REQ-012 EXEC/MEM/WB fields from op_q: ALU_op_o R=010, addi=110, slti=111, lw/sw=000, beq=001; ALUSrc_o=1 for addi/slti/lw/sw; RegDst_o=1 only R; memtoreg_o=1 only lw; all 0 in IDLE/IFETCH/DECODE/ERROR.
REQ-013 EXEC: beq -> Branch_o=1 one cycle, -> IFETCH; j -> jump_o=1 one cycle, -> IFETCH; R/addi/slti -> WB; lw/sw -> MEM.
REQ-014 MEM: lw mem_read_o=1, sw mem_write_o=1, held until mem_ready_i=1; then lw -> WB, sw -> IFETCH.
REQ-015 WB: RegWrite_o=1 exactly one cycle; -> IFETCH.
REQ-016 Latency (zero-wait memory): R/addi/slti/lw-without-MEM-wait per path: R 4 cycles, lw 5, sw 4, beq 3, j 3.
REQ-017 retire_cnt_o SHALL increment by 1 on every transition into IFETCH from EXEC, MEM or WB; wraps 2^CNT_W-1 -> 0.
REQ-018 Wait counter SHALL clear on entry to IFETCH/MEM and count cycles with mem_ready_i=0; reaching MEM_WAIT_MAX (nonzero) -> ERROR; mem_ready_i=1 in the same cycle as the limit wins (normal transition).
REQ-019 ERROR: err_o=1, all other controls 0, retire_cnt_o frozen; exit only by reset.

Reset
REQ-020 rst_i=0 SHALL immediately (asynchronously) force IDLE, op_q=0, wait counter=0, retire_cnt_o=0, all outputs 0, including mid-access strobes.

Configuration
REQ-021 Macro CTRL_JUMP_EN: defined -> opcode 000010 legal, drives jump_o per REQ-013; undefined -> 000010 illegal per REQ-010, jump_o tied 0.

Structure
REQ-022 Package ctrl_pkg SHALL hold opcode constants, ALU_op encodings, state encoding (IDLE=0..ERROR=6).
REQ-023 Combinational sub-module op_class_dec SHALL map opcode to class, legal flag and static fields; FSM instantiates it on op_q.

Verification
REQ-024 Reset then R-type, mem_ready_i always 1 -> states IDLE,IFETCH,DECODE,EXEC,WB; RegWrite_o=1, RegDst_o=1, ALU_op_o=010 in WB; retire_cnt_o=1.
REQ-025 lw with mem_ready_i low 3 cycles in MEM -> mem_read_o held 4 cycles, then WB with memtoreg_o=1, RegWrite_o=1.
REQ-026 MEM_WAIT_MAX=15, mem_ready_i stuck 0 in IFETCH -> ERROR after 15 cycles, err_o=1 until rst_i=0.
REQ-027 Opcode 111111 -> illegal_o pulse one cycle, back to IFETCH, retire_cnt_o unchanged; j likewise without CTRL_JUMP_EN, jump_o=1 with it.
REQ-028 CNT_W=4, 16 beq instructions -> retire_cnt_o wraps to 0; rst_i=0 during sw MEM -> mem_write_o drops same cycle, state_o=IDLE.

Source files
------------

// File: rtl/ctrl_fsm_multicycle_pkg.sv
// Shared opcode, ALU-class and state encodings for the multicycle controller.
// Optional feature: CTRL_JUMP_EN makes opcode 000010 (j) a legal instruction.
package ctrl_pkg;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_SLTI = 6'b001010;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;

  localparam logic [2:0] ALU_MEM  = 3'b000;
  localparam logic [2:0] ALU_BEQ  = 3'b001;
  localparam logic [2:0] ALU_R    = 3'b010;
  localparam logic [2:0] ALU_ADDI = 3'b110;
  localparam logic [2:0] ALU_SLTI = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IFETCH = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILL,
    CLS_ALU,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J
  } op_class_t;

  function automatic logic is_mem_class(op_class_t c);
    return (c == CLS_LW) || (c == CLS_SW);
  endfunction

endpackage

// File: rtl/ctrl_fsm_multicycle_if.sv
// Controller-to-datapath bundle. master = controller, slave = datapath/memory side.
// Handshake: a strobe (mem_read_o/mem_write_o) holds until a cycle with mem_ready_i=1; that cycle completes the access.
interface ctrl_fsm_multicycle_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
);
  logic [OP_W-1:0]    instr_op_i;
  logic               mem_ready_i;
  logic               pc_write_o;
  logic               ir_write_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic               RegWrite_o;
  logic               RegDst_o;
  logic               ALUSrc_o;
  logic               memtoreg_o;
  logic               Branch_o;
  logic               jump_o;
  logic [ALUOP_W-1:0] ALU_op_o;
  logic [2:0]         state_o;
  logic               illegal_o;
  logic               err_o;
  logic [CNT_W-1:0]   retire_cnt_o;

  modport master (
    input  instr_op_i, mem_ready_i,
    output pc_write_o, ir_write_o, mem_read_o, mem_write_o,
           RegWrite_o, RegDst_o, ALUSrc_o, memtoreg_o, Branch_o, jump_o,
           ALU_op_o, state_o, illegal_o, err_o, retire_cnt_o
  );

  modport slave (
    output instr_op_i, mem_ready_i,
    input  pc_write_o, ir_write_o, mem_read_o, mem_write_o,
           RegWrite_o, RegDst_o, ALUSrc_o, memtoreg_o, Branch_o, jump_o,
           ALU_op_o, state_o, illegal_o, err_o, retire_cnt_o
  );
endinterface

// File: rtl/ctrl_fsm_multicycle_op_class_dec.sv
// Opcode decoder: instruction class, legality and the static datapath fields.
// With CTRL_JUMP_EN undefined the j opcode decodes as illegal.
module op_class_dec
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic [OP_W-1:0]    op,
  output op_class_t          cls,
  output logic               legal,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic               reg_dst,
  output logic               mem_to_reg
);

  always_comb begin
    cls        = CLS_ILL;
    alu_op     = '0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    case (op)
      OP_W'(OPC_R):    begin cls = CLS_ALU; alu_op = ALUOP_W'(ALU_R); reg_dst = 1'b1; end
      OP_W'(OPC_ADDI): begin cls = CLS_ALU; alu_op = ALUOP_W'(ALU_ADDI); alu_src = 1'b1; end
      OP_W'(OPC_SLTI): begin cls = CLS_ALU; alu_op = ALUOP_W'(ALU_SLTI); alu_src = 1'b1; end
      OP_W'(OPC_LW):   begin
        cls = CLS_LW; alu_op = ALUOP_W'(ALU_MEM); alu_src = 1'b1; mem_to_reg = 1'b1;
      end
      OP_W'(OPC_SW):   begin cls = CLS_SW; alu_op = ALUOP_W'(ALU_MEM); alu_src = 1'b1; end
      OP_W'(OPC_BEQ):  begin cls = CLS_BEQ; alu_op = ALUOP_W'(ALU_BEQ); end
`ifdef CTRL_JUMP_EN
      OP_W'(OPC_J):    cls = CLS_J;
`endif
      default: ;
    endcase
    legal = (cls != CLS_ILL);
  end

endmodule

// File: rtl/ctrl_fsm_multicycle.sv
// Multicycle Moore controller: IDLE/IFETCH/DECODE/EXEC/MEM/WB/ERROR with memory-wait timeout.
// Optional feature macro: CTRL_JUMP_EN (j opcode legal, drives jump_o in EXEC).
module ctrl_fsm_multicycle
  import ctrl_pkg::*;
#(
  parameter int OP_W         = 6,
  parameter int ALUOP_W      = 3,
  parameter int CNT_W        = 16,
  parameter int MEM_WAIT_MAX = 15
) (
  input logic                  clk_i,
  input logic                  rst_i,
  ctrl_fsm_multicycle_if.master bus
);

  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  state_t              state;
  logic [OP_W-1:0]     op_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]    retire_cnt;

  logic [OP_W-1:0]     dec_op;
  op_class_t           dec_cls;
  logic                dec_legal;
  logic [ALUOP_W-1:0]  dec_alu;
  logic                dec_alu_src;
  logic                dec_reg_dst;
  logic                dec_mem_to_reg;
  logic                timeout;

  // DECODE judges the live opcode; every later state decodes the latched one.
  assign dec_op  = (state == ST_DECODE) ? bus.instr_op_i : op_q;
  assign timeout = (MEM_WAIT_MAX != 0) && (wait_cnt == WAIT_LIMIT);

  op_class_dec #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) u_dec (
    .op         (dec_op),
    .cls        (dec_cls),
    .legal      (dec_legal),
    .alu_op     (dec_alu),
    .alu_src    (dec_alu_src),
    .reg_dst    (dec_reg_dst),
    .mem_to_reg (dec_mem_to_reg)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      wait_cnt   <= '0;
      retire_cnt <= '0;
    end else begin
      // The wait counter only survives stalled IFETCH/MEM cycles.
      wait_cnt <= '0;
      case (state)
        ST_IDLE: state <= ST_IFETCH;
        ST_IFETCH: begin
          if (bus.mem_ready_i)  state <= ST_DECODE;
          else if (timeout)     state <= ST_ERROR;
          else                  wait_cnt <= wait_cnt + 1'b1;
        end
        ST_DECODE: begin
          op_q  <= bus.instr_op_i;
          state <= dec_legal ? ST_EXEC : ST_IFETCH;
        end
        ST_EXEC: begin
          case (dec_cls)
            CLS_ALU:         state <= ST_WB;
            CLS_LW, CLS_SW:  state <= ST_MEM;
            CLS_BEQ, CLS_J: begin
              state      <= ST_IFETCH;
              retire_cnt <= retire_cnt + 1'b1;
            end
            default:         state <= ST_IFETCH;
          endcase
        end
        ST_MEM: begin
          if (bus.mem_ready_i) begin
            if (dec_cls == CLS_LW) begin
              state <= ST_WB;
            end else begin
              state      <= ST_IFETCH;
              retire_cnt <= retire_cnt + 1'b1;
            end
          end else if (timeout) begin
            state <= ST_ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WB: begin
          state      <= ST_IFETCH;
          retire_cnt <= retire_cnt + 1'b1;
        end
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  logic pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, alu_src, mem_to_reg;
  logic branch, jump, illegal, err;
  logic [ALUOP_W-1:0] alu_op;

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    illegal    = 1'b0;
    err        = 1'b0;
    alu_op     = '0;
    if ((state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB)) begin
      alu_op     = dec_alu;
      alu_src    = dec_alu_src;
      reg_dst    = dec_reg_dst;
      mem_to_reg = dec_mem_to_reg;
    end
    case (state)
      ST_IFETCH: begin
        mem_read = 1'b1;
        pc_write = bus.mem_ready_i;
        ir_write = bus.mem_ready_i;
      end
      ST_DECODE: illegal = !dec_legal;
      ST_EXEC: begin
        branch = (dec_cls == CLS_BEQ);
`ifdef CTRL_JUMP_EN
        jump   = (dec_cls == CLS_J);
`else
        jump   = 1'b0;
`endif
      end
      ST_MEM: begin
        mem_read  = is_mem_class(dec_cls) && (dec_cls == CLS_LW);
        mem_write = (dec_cls == CLS_SW);
      end
      ST_WB:    reg_write = 1'b1;
      ST_ERROR: err = 1'b1;
      default: ;
    endcase
  end

  assign bus.pc_write_o   = pc_write;
  assign bus.ir_write_o   = ir_write;
  assign bus.mem_read_o   = mem_read;
  assign bus.mem_write_o  = mem_write;
  assign bus.RegWrite_o   = reg_write;
  assign bus.RegDst_o     = reg_dst;
  assign bus.ALUSrc_o     = alu_src;
  assign bus.memtoreg_o   = mem_to_reg;
  assign bus.Branch_o     = branch;
  assign bus.jump_o       = jump;
  assign bus.ALU_op_o     = alu_op;
  assign bus.state_o      = state;
  assign bus.illegal_o    = illegal;
  assign bus.err_o        = err;
  assign bus.retire_cnt_o = retire_cnt;

endmodule

// File: tb/tb_ctrl_fsm_multicycle.sv
// Bench for ctrl_fsm_multicycle: opcode trace table, instruction-level model with random waits, corner sequences.
// Honours CTRL_JUMP_EN the same way as the design.
module tb_ctrl_fsm_multicycle;

  localparam int OP_W = 6, ALUOP_W = 3, CNT_W = 4, MEM_WAIT_MAX = 15, EXP_W = 22;

  localparam logic [5:0] T_R = 6'b000000, T_ADDI = 6'b001000, T_SLTI = 6'b001010;
  localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_BEQ = 6'b000100;
  localparam logic [5:0] T_J = 6'b000010, T_BAD = 6'b111111;
  localparam logic [2:0] S_IDLE = 3'd0, S_IFETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
  localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_ERROR = 3'd6;
  localparam int C_PCW = 9, C_IRW = 8, C_MRD = 7, C_MWR = 6, C_RW = 5;
  localparam int C_RD = 4, C_AS = 3, C_M2R = 2, C_BR = 1, C_JP = 0;
  localparam int K_ILL = 0, K_ALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  ctrl_fsm_multicycle_if #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

  ctrl_fsm_multicycle #(
    .OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W), .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  logic [EXP_W-1:0] obs;
  assign obs = {bus.state_o, bus.pc_write_o, bus.ir_write_o, bus.mem_read_o, bus.mem_write_o,
                bus.RegWrite_o, bus.RegDst_o, bus.ALUSrc_o, bus.memtoreg_o, bus.Branch_o,
                bus.jump_o, bus.ALU_op_o, bus.illegal_o, bus.err_o, bus.retire_cnt_o};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int rc       = 0;

  typedef struct packed { logic ready; logic [5:0] op; } stim_t;
  stim_t            stim_q[$];
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] b(input int i);
    return 10'(1) << i;
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rr();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [EXP_W-1:0] mk(input logic [2:0] st, input logic [9:0] ctl,
                                          input logic [2:0] alu, input logic ill, input logic err);
    return {st, ctl, alu, ill, err, 4'(rc % 16)};
  endfunction

  // Instruction semantics straight from the opcode table.
  function automatic int op_kind(input logic [5:0] op, output logic [2:0] alu,
                                 output logic as, output logic rd, output logic m2r);
    int k;
    k = K_ILL; alu = 3'b000; as = 1'b0; rd = 1'b0; m2r = 1'b0;
    case (op)
      T_R:    begin k = K_ALU; alu = 3'b010; rd = 1'b1; end
      T_ADDI: begin k = K_ALU; alu = 3'b110; as = 1'b1; end
      T_SLTI: begin k = K_ALU; alu = 3'b111; as = 1'b1; end
      T_LW:   begin k = K_LW;  as = 1'b1; m2r = 1'b1; end
      T_SW:   begin k = K_SW;  as = 1'b1; end
      T_BEQ:  begin k = K_BEQ; alu = 3'b001; end
`ifdef CTRL_JUMP_EN
      T_J:    k = K_J;
`endif
      default: ;
    endcase
    return k;
  endfunction

  task automatic push(input logic rdy, input logic [5:0] op, input logic [EXP_W-1:0] e);
    stim_q.push_back('{rdy, op});
    exp_q.push_back(e);
  endtask

  // Expands one instruction into its cycle-by-cycle inputs and expected outputs.
  task automatic plan_instr(input logic [5:0] op, input int iw, input int mw);
    logic [2:0] alu;
    logic as, rd, m2r;
    logic [9:0] f, fm;
    int kind;
    kind = op_kind(op, alu, as, rd, m2r);
    for (int k = 0; k < iw; k++) push(1'b0, rop(), mk(S_IFETCH, b(C_MRD), 3'b0, 1'b0, 1'b0));
    push(1'b1, rop(), mk(S_IFETCH, b(C_PCW) | b(C_IRW) | b(C_MRD), 3'b0, 1'b0, 1'b0));
    push(rr(), op, mk(S_DECODE, 10'b0, 3'b0, kind == K_ILL, 1'b0));
    if (kind == K_ILL) return;
    f = (as ? b(C_AS) : 10'b0) | (rd ? b(C_RD) : 10'b0) | (m2r ? b(C_M2R) : 10'b0);
    push(rr(), rop(), mk(S_EXEC, f | ((kind == K_BEQ) ? b(C_BR) : 10'b0)
                                   | ((kind == K_J) ? b(C_JP) : 10'b0), alu, 1'b0, 1'b0));
    if (kind == K_BEQ || kind == K_J) begin rc++; return; end
    if (kind == K_LW || kind == K_SW) begin
      fm = f | ((kind == K_LW) ? b(C_MRD) : b(C_MWR));
      for (int k = 0; k < mw; k++) push(1'b0, rop(), mk(S_MEM, fm, alu, 1'b0, 1'b0));
      push(1'b1, rop(), mk(S_MEM, fm, alu, 1'b0, 1'b0));
      if (kind == K_SW) begin rc++; return; end
    end
    push(rr(), rop(), mk(S_WB, f | b(C_RW), alu, 1'b0, 1'b0));
    rc++;
  endtask

  // ---------------- driver ----------------
  task automatic run_plan(input int max_n);
    stim_t s;
    logic [EXP_W-1:0] e;
    int n;
    n = 0;
    while (stim_q.size() > 0 && (max_n < 0 || n < max_n)) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      bus.mem_ready_i = s.ready;
      bus.instr_op_i  = s.op;
      #1;
      check("cycle", 32'(obs), 32'(e));
      n++;
    end
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic apply_reset(input string name);
    rst_i = 1'b0;
    #1;
    check(name, 32'(obs), 32'd0);
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    #1;
    check("reset_hold", 32'(obs), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    rc = 0;
    #1;
    check("idle", 32'(obs), 32'd0);
  endtask

  // ---------------- opcode trace table ----------------
  typedef struct {
    logic [5:0]  op;
    int          len;
    logic [14:0] st;
    logic [2:0]  alu;
    int          ret;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  function automatic logic [14:0] tr(input logic [2:0] a, input logic [2:0] b2, input logic [2:0] c,
                                     input logic [2:0] d, input logic [2:0] e);
    return {e, d, c, b2, a};
  endfunction

  logic [5:0] ops[8];
  logic [14:0] st_w;
  logic [2:0] es;
  logic [5:0] pick;
  int iw, mw;

  initial begin
    rst_i = 1'b1;
    bus.mem_ready_i = 1'b0;
    bus.instr_op_i  = '0;
    ops = '{T_R, T_ADDI, T_SLTI, T_LW, T_SW, T_BEQ, T_J, T_BAD};

    vecs[0] = '{T_R,    4, tr(S_IFETCH, S_DECODE, S_EXEC, S_WB, S_IDLE),  3'b010, 1};
    vecs[1] = '{T_ADDI, 4, tr(S_IFETCH, S_DECODE, S_EXEC, S_WB, S_IDLE),  3'b110, 1};
    vecs[2] = '{T_SLTI, 4, tr(S_IFETCH, S_DECODE, S_EXEC, S_WB, S_IDLE),  3'b111, 1};
    vecs[3] = '{T_LW,   5, tr(S_IFETCH, S_DECODE, S_EXEC, S_MEM, S_WB),   3'b000, 1};
    vecs[4] = '{T_SW,   4, tr(S_IFETCH, S_DECODE, S_EXEC, S_MEM, S_IDLE), 3'b000, 1};
    vecs[5] = '{T_BEQ,  3, tr(S_IFETCH, S_DECODE, S_EXEC, S_IDLE, S_IDLE), 3'b001, 1};
`ifdef CTRL_JUMP_EN
    vecs[6] = '{T_J,    3, tr(S_IFETCH, S_DECODE, S_EXEC, S_IDLE, S_IDLE), 3'b000, 1};
`else
    vecs[6] = '{T_J,    2, tr(S_IFETCH, S_DECODE, S_IDLE, S_IDLE, S_IDLE), 3'b000, 0};
`endif
    vecs[7] = '{T_BAD,  2, tr(S_IFETCH, S_DECODE, S_IDLE, S_IDLE, S_IDLE), 3'b000, 0};
    vecs[8] = '{6'b000001, 2, tr(S_IFETCH, S_DECODE, S_IDLE, S_IDLE, S_IDLE), 3'b000, 0};

    #2;
    apply_reset("reset");

    // Zero-wait traces and the retire count seen at each instruction start.
    for (int v = 0; v < NV; v++) begin
      st_w = vecs[v].st;
      for (int i = 0; i < vecs[v].len; i++) begin
        @(negedge clk);
        bus.mem_ready_i = 1'b1;
        bus.instr_op_i  = (i == 1) ? vecs[v].op : rop();
        #1;
        es = st_w[3*i +: 3];
        if (i == 0) check("vec_retire", 32'(bus.retire_cnt_o), 32'(rc % 16));
        check("vec_state", 32'(bus.state_o), 32'(es));
        if (es == S_EXEC) check("vec_alu", 32'(bus.ALU_op_o), 32'(vecs[v].alu));
      end
      rc += vecs[v].ret;
    end

    // Wait-state corners: lw with 3 MEM stalls, and one stall short of the timeout.
    plan_instr(T_LW, 0, 3);
    plan_instr(T_R, 14, 0);
    plan_instr(T_SW, 0, 14);
    plan_instr(T_LW, 14, 14);
    plan_instr(T_BAD, 2, 0);
    run_plan(-1);

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      pick = ($urandom_range(0, 4) == 0) ? rop() : ops[$urandom_range(0, 7)];
      iw = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
      plan_instr(pick, iw, mw);
      run_plan(-1);
    end

    // Fetch timeout: 15 stalled IFETCH cycles, then sticky ERROR with frozen count.
    apply_reset("reset_before_timeout");
    plan_instr(T_R, 0, 0);
    for (int k = 0; k < 15; k++) push(1'b0, rop(), mk(S_IFETCH, b(C_MRD), 3'b0, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++)  push(rr(), rop(), mk(S_ERROR, 10'b0, 3'b0, 1'b0, 1'b1));
    run_plan(-1);
    apply_reset("reset_clears_err");

    // Retire counter wraps after 16 branches.
    for (int k = 0; k < 16; k++) plan_instr(T_BEQ, 0, 0);
    run_plan(-1);
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    check("retire_wrap", 32'(bus.retire_cnt_o), 32'(rc % 16));
    check("retire_wrap_zero", 32'(bus.retire_cnt_o), 32'd0);

    // Reset mid-store: strobe must fall without waiting for a clock edge.
    apply_reset("reset_before_sw");
    plan_instr(T_SW, 0, 5);
    run_plan(5);
    apply_reset("rst_mid_access");
    plan_instr(T_ADDI, 1, 0);
    run_plan(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
